// File: rtl/delay_line_server_pkg.sv
// Shared definitions for the delay-line memory server: op encodings, FSM state
// constants and request-word field layout.
package delay_line_server_pkg;

    typedef enum logic {
        DL_OP_READ  = 1'b0,
        DL_OP_WRITE = 1'b1
    } dl_op_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CALC     = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_MEM = 3'd3;
    localparam logic [2:0] ST_RESPOND  = 3'd4;

    // Request word: op sits just above the payload, payload starts at bit 0.
    localparam int DL_PAYLOAD_LSB = 0;

    function automatic int dl_op_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/delay_line_regfile.sv
// Per-handle base/len/head storage with a config port, a head-advance port and
// a read port whose result is latched for use in the following cycles.
module delay_line_regfile
    import delay_line_server_pkg::*;
#(
    parameter int addr_width   = 16,
    parameter int handle_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [handle_width-1:0] cfg_handle,
    input  logic [addr_width-1:0]   cfg_base,
    input  logic [addr_width-1:0]   cfg_len,
    input  logic                    adv_en,
    input  logic [handle_width-1:0] adv_handle,
    input  logic [addr_width-1:0]   adv_head,
    input  logic                    rd_en,
    input  logic [handle_width-1:0] rd_handle,
    output logic [addr_width-1:0]   rd_base,
    output logic [addr_width-1:0]   rd_len,
    output logic [addr_width-1:0]   rd_head
);

    localparam int num_lines = 2 ** handle_width;

    logic [addr_width-1:0] base_q [num_lines];
    logic [addr_width-1:0] base_d [num_lines];
    logic [addr_width-1:0] len_q  [num_lines];
    logic [addr_width-1:0] len_d  [num_lines];
    logic [addr_width-1:0] head_q [num_lines];
    logic [addr_width-1:0] head_d [num_lines];

    logic [addr_width-1:0] rd_base_q, rd_base_d;
    logic [addr_width-1:0] rd_len_q,  rd_len_d;
    logic [addr_width-1:0] rd_head_q, rd_head_d;

    // Config is applied after the head advance so it wins on a same-handle clash.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        head_d = head_q;
        if (adv_en) begin
            head_d[adv_handle] = adv_head;
        end
        if (cfg_we) begin
            base_d[cfg_handle] = cfg_base;
            len_d[cfg_handle]  = cfg_len;
            head_d[cfg_handle] = '0;
        end
    end

    always_comb begin
        rd_base_d = rd_base_q;
        rd_len_d  = rd_len_q;
        rd_head_d = rd_head_q;
        if (rd_en) begin
            rd_base_d = base_q[rd_handle];
            rd_len_d  = len_q[rd_handle];
            rd_head_d = head_q[rd_handle];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= '{default: '0};
            len_q     <= '{default: '0};
            head_q    <= '{default: '0};
            rd_base_q <= '0;
            rd_len_q  <= '0;
            rd_head_q <= '0;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            head_q    <= head_d;
            rd_base_q <= rd_base_d;
            rd_len_q  <= rd_len_d;
            rd_head_q <= rd_head_d;
        end
    end

    assign rd_base = rd_base_q;
    assign rd_len  = rd_len_q;
    assign rd_head = rd_head_q;

endmodule

// File: rtl/delay_line_server.sv
// Memory server that maps per-handle circular delay-line requests onto a single
// external sample memory, one access at a time.
module delay_line_server
    import delay_line_server_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int addr_width     = 16,
    parameter int handle_width   = 8,
    parameter int timeout_cycles = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arbiter_req,
    input  logic [data_width:0]     arbiter_req_data,
    input  logic [handle_width-1:0] arbiter_req_handle,
    output logic [data_width-1:0]   server_data,
    output logic                    server_ready,
    input  logic                    cfg_we,
    input  logic [handle_width-1:0] cfg_handle,
    input  logic [addr_width-1:0]   cfg_base,
    input  logic [addr_width-1:0]   cfg_len,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [addr_width-1:0]   mem_addr,
    output logic [data_width-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [data_width-1:0]   mem_rdata,
    output logic                    err_timeout,
    output logic                    err_overrun
);

    localparam int op_bit = dl_op_bit(data_width);
    localparam int cw     = ((data_width > addr_width) ? data_width : addr_width) + 1;
    localparam int tmo_w  = $clog2(timeout_cycles + 1);
    localparam logic [cw-1:0]    one_c    = cw'(1);
    localparam logic [tmo_w-1:0] tmo_last = tmo_w'(timeout_cycles - 1);

    logic [2:0]              state_q, state_d;
    logic                    op_q, op_d;
    logic [data_width-1:0]   payload_q, payload_d;
    logic [handle_width-1:0] handle_q, handle_d;
    logic [data_width-1:0]   server_data_q, server_data_d;
    logic                    server_ready_q, server_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [addr_width-1:0]   mem_addr_q, mem_addr_d;
    logic [data_width-1:0]   mem_wdata_q, mem_wdata_d;
    logic [tmo_w-1:0]        tmo_q, tmo_d;
    logic                    err_timeout_q, err_timeout_d;
    logic                    err_overrun_q, err_overrun_d;

    logic                  rd_en;
    logic                  adv_en;
    logic [addr_width-1:0] rd_base, rd_len, rd_head;
    logic [addr_width-1:0] adv_head;
    logic [addr_width-1:0] read_addr, write_addr;
    logic [cw-1:0]         off_raw, len_m1, off_clamped, head_ext, len_ext, idx_ext, head_inc;

    delay_line_regfile #(
        .addr_width   (addr_width),
        .handle_width (handle_width)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_handle (cfg_handle),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .adv_en     (adv_en),
        .adv_handle (handle_q),
        .adv_head   (adv_head),
        .rd_en      (rd_en),
        .rd_handle  (arbiter_req_handle),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .rd_head    (rd_head)
    );

    // Read taps count back from the newest sample (head-1); offsets past the
    // line length clamp to the oldest sample, and the line index wraps by len.
    always_comb begin
        off_raw     = cw'(payload_q);
        len_ext     = cw'(rd_len);
        head_ext    = cw'(rd_head);
        len_m1      = len_ext - one_c;
        off_clamped = (off_raw > len_m1) ? len_m1 : off_raw;
        if (head_ext > off_clamped) begin
            idx_ext = head_ext - one_c - off_clamped;
        end else begin
            idx_ext = head_ext + len_ext - one_c - off_clamped;
        end
        read_addr  = rd_base + idx_ext[addr_width-1:0];
        write_addr = rd_base + rd_head;
        head_inc   = head_ext + one_c;
        adv_head   = (head_inc == len_ext) ? '0 : head_inc[addr_width-1:0];
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        payload_d      = payload_q;
        handle_d       = handle_q;
        server_data_d  = server_data_q;
        server_ready_d = 1'b0;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        tmo_d          = tmo_q;
        err_timeout_d  = err_timeout_q;
        err_overrun_d  = err_overrun_q;
        rd_en          = 1'b0;
        adv_en         = 1'b0;

        if (arbiter_req && (state_q != ST_IDLE)) begin
            err_overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arbiter_req) begin
                    rd_en     = 1'b1;
                    op_d      = arbiter_req_data[op_bit];
                    payload_d = arbiter_req_data[data_width-1:DL_PAYLOAD_LSB];
                    handle_d  = arbiter_req_handle;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                tmo_d = '0;
                if (rd_len == '0) begin
                    server_data_d  = '0;
                    server_ready_d = 1'b1;
                    state_d        = ST_RESPOND;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = (op_q == DL_OP_WRITE);
                    if (op_q == DL_OP_WRITE) begin
                        mem_addr_d  = write_addr;
                        mem_wdata_d = payload_q;
                    end else begin
                        mem_addr_d = read_addr;
                    end
                    state_d = ST_ISSUE;
                end
            end
            // The first request cycle can already be acknowledged by zero-wait memory.
            ST_ISSUE, ST_WAIT_MEM: begin
                if (mem_ack) begin
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    server_ready_d = 1'b1;
                    state_d        = ST_RESPOND;
                    if (op_q == DL_OP_WRITE) begin
                        server_data_d = payload_q;
                        adv_en        = 1'b1;
                    end else begin
                        server_data_d = mem_rdata;
                    end
                end else if (tmo_q == tmo_last) begin
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    err_timeout_d  = 1'b1;
                    server_data_d  = '0;
                    server_ready_d = 1'b1;
                    state_d        = ST_RESPOND;
                end else begin
                    tmo_d   = tmo_q + tmo_w'(1);
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= 1'b0;
            payload_q      <= '0;
            handle_q       <= '0;
            server_data_q  <= '0;
            server_ready_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            tmo_q          <= '0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            payload_q      <= payload_d;
            handle_q       <= handle_d;
            server_data_q  <= server_data_d;
            server_ready_q <= server_ready_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            tmo_q          <= tmo_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign server_data  = server_data_q;
    assign server_ready = server_ready_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_delay_line_server.sv
// Directed bench for delay_line_server: vector table for the circular-buffer
// behaviour plus hand sequences for timeout, overrun and mid-access reset.
module tb_delay_line_server;
    import delay_line_server_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        arbiter_req;
    logic [16:0] arbiter_req_data;
    logic [7:0]  arbiter_req_handle;
    logic [15:0] server_data;
    logic        server_ready;
    logic        cfg_we;
    logic [7:0]  cfg_handle;
    logic [15:0] cfg_base;
    logic [15:0] cfg_len;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        err_timeout;
    logic        err_overrun;

    int checks = 0;
    int failures = 0;
    int ready_count = 0;
    bit ack_enable = 1'b1;
    int mem_latency = 0;
    int ack_wait = 0;
    logic [15:0] mem_model [0:65535];

    typedef struct {
        bit          do_cfg;
        logic [15:0] base_v;
        logic [15:0] len_v;
        logic        op;
        logic [15:0] payload;
        logic [7:0]  handle;
        logic [15:0] exp_data;
        logic [15:0] exp_addr;
        bit          exp_mem;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    delay_line_server #(
        .data_width     (16),
        .addr_width     (16),
        .handle_width   (8),
        .timeout_cycles (255)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .arbiter_req        (arbiter_req),
        .arbiter_req_data   (arbiter_req_data),
        .arbiter_req_handle (arbiter_req_handle),
        .server_data        (server_data),
        .server_ready       (server_ready),
        .cfg_we             (cfg_we),
        .cfg_handle         (cfg_handle),
        .cfg_base           (cfg_base),
        .cfg_len            (cfg_len),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .err_timeout        (err_timeout),
        .err_overrun        (err_overrun)
    );

    always #5 clk = ~clk;

    // Memory model: acknowledges after mem_latency request cycles when enabled.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req && ack_enable) begin
            if (ack_wait >= mem_latency) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model[mem_addr];
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                ack_wait  = 0;
            end else begin
                ack_wait++;
            end
        end else if (!mem_req) begin
            ack_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (server_ready) ready_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [16:0] data, input logic [7:0] handle);
        arbiter_req        = req;
        arbiter_req_data   = data;
        arbiter_req_handle = handle;
    endtask

    task automatic cfgWrite(input logic [7:0] handle, input logic [15:0] base, input logic [15:0] len);
        @(negedge clk);
        cfg_we = 1'b1; cfg_handle = handle; cfg_base = base; cfg_len = len;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Issues one request and waits (bounded) for server_ready; lat counts
    // cycles from the request cycle to the ready cycle.
    task automatic runRequest(input logic op, input logic [15:0] payload, input logic [7:0] handle,
                              input bit inject, output logic [15:0] data, output int lat,
                              output logic [15:0] addr, output bit saw_req);
        bit injected = 1'b0;
        data = '0; lat = 0; addr = '0; saw_req = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, {op, payload}, handle);
        while (1) begin
            @(negedge clk);
            lat++;
            arbiter_req = 1'b0;
            if (server_ready) begin
                data = server_data;
                break;
            end
            if (mem_req) begin
                saw_req = 1'b1;
                addr    = mem_addr;
                if (inject && !injected) begin
                    applyStimulus(1'b1, {DL_OP_WRITE, 16'h0099}, handle);
                    injected = 1'b1;
                end
            end
            if (lat >= 400) begin
                checks++;
                failures++;
                $display("[TB] FAIL ready_wait actual=no_ready expected=ready");
                break;
            end
        end
        @(negedge clk);
        checkOutput("ready_single_cycle", server_ready, 1'b0);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] a;
        int          lat;
        bit          saw;
        int          rc;

        for (int i = 0; i < 65536; i++) mem_model[i] = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        cfg_we = 1'b0; cfg_handle = '0; cfg_base = '0; cfg_len = '0;
        applyStimulus(1'b0, '0, '0);

        vecs[0]  = '{1'b1, 16'h0100, 16'd4, DL_OP_WRITE, 16'd10, 8'd3, 16'd10, 16'h0100, 1'b1, 3};
        vecs[1]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd20, 8'd3, 16'd20, 16'h0101, 1'b1, 3};
        vecs[2]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd30, 8'd3, 16'd30, 16'h0102, 1'b1, 3};
        vecs[3]  = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd0,  8'd3, 16'd30, 16'h0102, 1'b1, 3};
        vecs[4]  = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd2,  8'd3, 16'd10, 16'h0100, 1'b1, 3};
        vecs[5]  = '{1'b1, 16'h0100, 16'd4, DL_OP_WRITE, 16'd1,  8'd3, 16'd1,  16'h0100, 1'b1, 3};
        vecs[6]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd2,  8'd3, 16'd2,  16'h0101, 1'b1, 3};
        vecs[7]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd3,  8'd3, 16'd3,  16'h0102, 1'b1, 3};
        vecs[8]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd4,  8'd3, 16'd4,  16'h0103, 1'b1, 3};
        vecs[9]  = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'd5,  8'd3, 16'd5,  16'h0100, 1'b1, 3};
        vecs[10] = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd0,  8'd3, 16'd5,  16'h0100, 1'b1, 3};
        vecs[11] = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd3,  8'd3, 16'd2,  16'h0101, 1'b1, 3};
        vecs[12] = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd9,  8'd3, 16'd2,  16'h0101, 1'b1, 3};
        vecs[13] = '{1'b0, 16'h0000, 16'd0, DL_OP_READ,  16'd0,  8'd5, 16'd0,  16'h0000, 1'b0, 2};
        vecs[14] = '{1'b0, 16'h0000, 16'd0, DL_OP_WRITE, 16'h55, 8'd5, 16'd0,  16'h0000, 1'b0, 2};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_server_ready", server_ready, 1'b0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_server_data", server_data, 16'h0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
        checkOutput("rst_err_timeout", err_timeout, 1'b0);
        checkOutput("rst_err_overrun", err_overrun, 1'b0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_cfg) cfgWrite(vecs[i].handle, vecs[i].base_v, vecs[i].len_v);
            runRequest(vecs[i].op, vecs[i].payload, vecs[i].handle, 1'b0, d, lat, a, saw);
            checkOutput($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d_mem_req_seen", i), saw, vecs[i].exp_mem);
            if (vecs[i].exp_mem) checkOutput($sformatf("vec%0d_mem_addr", i), a, vecs[i].exp_addr);
        end

        // Stalled WRITE times out; head must stay at 1 so the retry lands at 0x101.
        ack_enable = 1'b0;
        rc = ready_count;
        runRequest(DL_OP_WRITE, 16'd77, 8'd3, 1'b0, d, lat, a, saw);
        repeat (4) @(negedge clk);
        checkOutput("tmo_data", d, 16'h0);
        checkOutput("tmo_latency", lat, 257);
        checkOutput("tmo_err_timeout", err_timeout, 1'b1);
        checkOutput("tmo_ready_pulses", ready_count - rc, 1);
        ack_enable = 1'b1;
        runRequest(DL_OP_WRITE, 16'd6, 8'd3, 1'b0, d, lat, a, saw);
        checkOutput("post_tmo_write_data", d, 16'd6);
        checkOutput("post_tmo_write_addr", a, 16'h0101);

        // Second request during the memory wait is dropped.
        checkOutput("pre_overrun_flag", err_overrun, 1'b0);
        mem_latency = 3;
        rc = ready_count;
        runRequest(DL_OP_READ, 16'd0, 8'd3, 1'b1, d, lat, a, saw);
        repeat (4) @(negedge clk);
        checkOutput("overrun_data", d, 16'd6);
        checkOutput("overrun_latency", lat, 6);
        checkOutput("overrun_flag", err_overrun, 1'b1);
        checkOutput("overrun_ready_pulses", ready_count - rc, 1);
        mem_latency = 0;
        runRequest(DL_OP_READ, 16'd0, 8'd3, 1'b0, d, lat, a, saw);
        checkOutput("overrun_dropped_data", d, 16'd6);
        checkOutput("overrun_dropped_addr", a, 16'h0101);

        // Reset while waiting on memory abandons the access.
        ack_enable = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, {DL_OP_READ, 16'd0}, 8'd3);
        lat = 0;
        @(negedge clk);
        arbiter_req = 1'b0;
        while (!mem_req && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rst_mid_mem_req_seen", mem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        rc = ready_count;
        @(negedge clk);
        checkOutput("rst_mid_mem_req_drop", mem_req, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("rst_mid_no_ready", ready_count - rc, 0);
        checkOutput("rst_mid_err_timeout", err_timeout, 1'b0);
        checkOutput("rst_mid_err_overrun", err_overrun, 1'b0);
        ack_enable = 1'b1;
        runRequest(DL_OP_READ, 16'd0, 8'd3, 1'b0, d, lat, a, saw);
        checkOutput("rst_cleared_len_latency", lat, 2);
        checkOutput("rst_cleared_len_mem_req", saw, 1'b0);
        cfgWrite(8'd3, 16'h0200, 16'd8);
        runRequest(DL_OP_WRITE, 16'h1234, 8'd3, 1'b0, d, lat, a, saw);
        checkOutput("rst_reconf_write_addr", a, 16'h0200);
        runRequest(DL_OP_READ, 16'd0, 8'd3, 1'b0, d, lat, a, saw);
        checkOutput("rst_reconf_read_data", d, 16'h1234);
        checkOutput("rst_reconf_read_addr", a, 16'h0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
